reset_sequencer: RTL
====================

# reset_sequencer

Releases a set of downstream reset domains in a fixed order after the global asynchronous reset and after software re-sequence requests. It sits after the reset synchronizer and drives one reset output per subsystem. Each subsystem reset is deasserted only after the previous subsystem reports ready, or after a per-stage timeout. A sticky error bit records every stage that timed out.

## Interface
- N_STAGES, 4: number of sequenced reset outputs; at least 2.
- HOLD_CYCLES, 16: cycles all resets stay asserted before stage 0 is released; at least 1.
- ACK_TIMEOUT, 255: maximum cycles to wait for `i_ready[k]` before moving on; at least 1.

- i_clk, input, 1: single clock. All logic is on the rising edge.
- i_areset, input, 1: asynchronous, active-high reset. Deassertion is already synchronized to `i_clk` upstream.
- i_sw_req, input, 1: one-cycle pulse that requests a full re-sequence.
- i_ready, input, N_STAGES: per-stage ready acknowledge. Only bit `o_stage` is sampled, and only in WAIT_ACK.
- o_rst, output, N_STAGES: per-stage active-high resets, registered.
- o_stage, output, $clog2(N_STAGES): index of the stage currently awaited.
- o_busy, output, 1: high while a sequence is in progress (HOLD or WAIT_ACK).
- o_done, output, 1: high in DONE.
- o_err, output, N_STAGES: sticky per-stage timeout flags.

## Operation
**Reset values** while `i_areset` is high, applied asynchronously:
- `o_rst` is all ones.
- State is HOLD with counter 0.
- `o_stage` = 0, `o_busy` = 1, `o_done` = 0, `o_err` = 0.

**States:**
- **HOLD**
  - The counter increments each cycle.
  - When counter == HOLD_CYCLES-1: `o_rst[0]` <= 0, `o_stage` <= 0, counter <= 0, next state WAIT_ACK.
- **WAIT_ACK**
  - The counter increments each cycle.
  - An event occurs when `i_ready[o_stage]` is 1, or when counter == ACK_TIMEOUT-1.
  - A timeout event sets `o_err[o_stage]` <= 1. If ready and timeout coincide, ready wins and no error is set.
  - On an event with `o_stage` < N_STAGES-1: `o_stage` increments, `o_rst[o_stage+1]` <= 0, counter <= 0.
  - On an event with `o_stage` == N_STAGES-1: next state DONE, `o_done` <= 1, `o_busy` <= 0.
- **DONE**
  - Holds until `i_sw_req`.

**Software request (`i_sw_req`):**
- In WAIT_ACK or DONE, on the next edge: `o_rst` <= all ones, `o_err` <= 0, `o_done` <= 0, `o_busy` <= 1, counter <= 0, `o_stage` <= 0, next state HOLD.
- A request in the same cycle as a WAIT_ACK event takes priority over that event.
- A request in HOLD is ignored; the count is not restarted.

**Invariants:**
- `o_rst` is a thermometer: if `o_rst[k]` == 0, then `o_rst[j]` == 0 for every j < k.
- Resets are released one bit per edge at most, and never out of order.
- Resets are asserted all together, either asynchronously (`i_areset`) or on one edge (`i_sw_req`).

`i_ready` bits for stages other than `o_stage` are don't-care.

## Timing
- **Cycle numbering:** edge 1 is the first rising edge after `i_areset` falls.
- **Stage 0 release:** `o_rst[0]` falls after edge HOLD_CYCLES.
- **Next-stage release:** `i_ready[k]` high when sampled at edge e releases `o_rst[k+1]` after edge e. The minimum spacing between releases is 1 cycle.
- **Timeout release:** with no ready, stage k+1 is released ACK_TIMEOUT cycles after stage k.
- **Best-case sequence:** readies tied high give `o_done` after edge HOLD_CYCLES+N_STAGES.
- **Worst-case sequence:** `o_done` after edge HOLD_CYCLES + N_STAGES·ACK_TIMEOUT.
- **Counter width:** one shared counter of $clog2(max(HOLD_CYCLES, ACK_TIMEOUT)) bits. It never wraps, because it is cleared on every terminal compare.
- **Reset mid-sequence:** `i_areset` asserted in any state returns every output to its reset value immediately, without waiting for a clock edge.

## Structure
- **Package `reset_seq_pkg`:** the state typedef (HOLD, WAIT_ACK, DONE) and a `clog2`-based width helper constant function.
- **Sub-modules:** none. The single module contains the FSM, the shared counter, and the output registers.

## Test plan
- **Power-on, readies tied high.** N=4, HOLD=16. Release `i_areset`.
  - Expect `o_rst` 1111→1110 after edge 16, then 1100, 1000, 0000 on successive edges.
  - Expect `o_done` = 1 after edge 20.
- **Stalled stage 2.** Hold `i_ready[2]` = 0 with ACK_TIMEOUT=8.
  - Expect `o_rst[3]` released exactly 8 cycles after `o_rst[2]`.
  - Expect `o_err` = 0100 and `o_done` = 1.
- **Ready/timeout coincidence.** Assert `i_ready[1]` on the cycle where counter == ACK_TIMEOUT-1.
  - Expect `o_err[1]` = 0 and stage 2 released on the next edge.
- **Software re-sequence.** In DONE with `o_err` = 0100, pulse `i_sw_req`.
  - Expect `o_rst` = 1111, `o_err` = 0, `o_done` = 0 next cycle, then a full sequence identical to the first test.
  - A pulse during HOLD changes nothing.
- **Reset mid-sequence.** Assert `i_areset` between clock edges while `o_rst` = 1100.
  - Expect `o_rst` = 1111 and `o_busy` = 1 before the next edge.
  - After `i_areset` falls, the sequence restarts from HOLD with a full HOLD_CYCLES count.
- **Continuous checks.** Throughout every test, check the thermometer invariant and that `i_ready` bits for non-current stages have no effect (drive them randomly).

Source files
------------

// File: rtl/reset_sequencer_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
// The package is named reset_seq_pkg and is imported by the interface and the top module.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        WAIT_ACK = 2'd1,
        DONE     = 2'd2
    } reset_state_t;

    // Width of the single counter shared by the hold and ack-timeout phases.
    // The result is never narrower than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Bundle of sequencer control inputs and per-stage reset/status outputs.
// The master modport is the sequencer; the slave modport is its environment.
interface reset_sequencer_if
    import reset_seq_pkg::*;
#(
    parameter int N_STAGES = 4
);
    localparam int SW = $clog2(N_STAGES);

    logic                i_sw_req;
    logic [N_STAGES-1:0] i_ready;
    logic [N_STAGES-1:0] o_rst;
    logic [SW-1:0]       o_stage;
    logic                o_busy;
    logic                o_done;
    logic [N_STAGES-1:0] o_err;
    reset_state_t        o_state;

    modport master (
        input  i_sw_req, i_ready,
        output o_rst, o_stage, o_busy, o_done, o_err, o_state
    );

    modport slave (
        output i_sw_req, i_ready,
        input  o_rst, o_stage, o_busy, o_done, o_err, o_state
    );

endinterface

// File: rtl/reset_sequencer.sv
// Releases per-subsystem resets in order, waiting for ready (or a timeout) from
// each stage; a software pulse re-asserts everything and restarts the sequence.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int N_STAGES    = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int ACK_TIMEOUT = 255
) (
    input logic               i_clk,
    input logic               i_areset,
    reset_sequencer_if.master bus
);

    localparam int CW = cnt_width(HOLD_CYCLES, ACK_TIMEOUT);
    localparam int SW = $clog2(N_STAGES);

    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] ACK_LAST   = CW'(ACK_TIMEOUT - 1);
    localparam logic [SW-1:0] LAST_STAGE = SW'(N_STAGES - 1);

    reset_state_t        state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [SW-1:0]       stage_q, stage_d;
    logic [N_STAGES-1:0] rst_q, rst_d;
    logic [N_STAGES-1:0] err_q, err_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic ready_hit;
    logic timeout_hit;
    logic restart;

    assign ready_hit   = bus.i_ready[stage_q];
    assign timeout_hit = (cnt_q == ACK_LAST);
    // Requests are ignored while holding, so the hold count always completes.
    assign restart     = bus.i_sw_req && (state_q != HOLD);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        rst_d   = rst_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = done_q;

        if (restart) begin
            state_d = HOLD;
            cnt_d   = '0;
            stage_d = '0;
            rst_d   = '1;
            err_d   = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        rst_d   = {{(N_STAGES-1){1'b1}}, 1'b0};
                        stage_d = '0;
                        cnt_d   = '0;
                        state_d = WAIT_ACK;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                WAIT_ACK: begin
                    if (ready_hit || timeout_hit) begin
                        if (!ready_hit) err_d[stage_q] = 1'b1;
                        cnt_d = '0;
                        if (stage_q == LAST_STAGE) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            // Shifting the thermometer releases exactly the next stage.
                            stage_d = stage_q + SW'(1);
                            rst_d   = rst_q << 1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DONE: ;
                default: state_d = HOLD;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            stage_q <= '0;
            rst_q   <= '1;
            err_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            rst_q   <= rst_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.o_rst   = rst_q;
    assign bus.o_stage = stage_q;
    assign bus.o_busy  = busy_q;
    assign bus.o_done  = done_q;
    assign bus.o_err   = err_q;
    assign bus.o_state = state_q;

endmodule
